// File: rtl/cal_hu_mac_pkg.sv
// ---------------------------------------------------------------------------
// cal_hu_mac_pkg
// Shared definitions for the Hu-moment pipelined multiply-accumulate unit.
//   - NUM_STAGE_MIN / NUM_STAGE_MAX : legal latency range of cal_hu_mac_pipe
//   - MAX_W                         : widest product/accumulator the helpers handle
//   - tag_t                         : per-sample {valid, clr, en} tag carried
//                                     alongside the data through the pipe
//   - ext_to_max()                  : sign/zero extension of a w-bit value
//   - sat_value()                   : clamp value for a w-bit accumulator
// ---------------------------------------------------------------------------
package cal_hu_mac_pkg;

  localparam int NUM_STAGE_MIN = 3;
  localparam int NUM_STAGE_MAX = 8;
  localparam int MAX_W         = 64;

  typedef struct packed {
    logic valid;
    logic clr;
    logic en;
  } tag_t;

  // Extend the low w bits of v to MAX_W bits. Bits at and above w are
  // replaced by the sign bit (sgn=1) or by zeros (sgn=0).
  function automatic logic [MAX_W-1:0] ext_to_max(input logic [MAX_W-1:0] v,
                                                  input int w,
                                                  input logic sgn);
    logic [MAX_W-1:0] r;
    r = v;
    for (int i = 0; i < MAX_W; i++) begin
      if (i >= w) r[i] = sgn & v[w-1];
    end
    return r;
  endfunction

  // Clamp value for a w-bit accumulator: all ones when unsigned, otherwise
  // the most positive (neg=0) or most negative (neg=1) two's complement value.
  function automatic logic [MAX_W-1:0] sat_value(input int w,
                                                 input logic sgn,
                                                 input logic neg);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w - 1)       r[i] = !sgn || !neg;
      else if (i == w - 1) r[i] = !sgn || neg;
    end
    return r;
  endfunction

endpackage

// File: rtl/cal_hu_mac_mul_core.sv
// ---------------------------------------------------------------------------
// cal_hu_mac_mul_core
// Pipelined multiplier covering register levels 1..NUM_STAGE-1 of the MAC:
//   level 1           : operand and tag capture
//   level 2           : product register
//   levels 3..NS-1    : pure delay of the product
// The per-sample tag travels in lock-step with the data.
// Ports:
//   clk, reset (sync, active high), ce (freezes every register when 0)
//   tag_in/din0/din1 : sample entering the pipe
//   tag_out/prod     : sample leaving level NUM_STAGE-1 (prod = low P_W bits)
// ---------------------------------------------------------------------------
module cal_hu_mac_mul_core
  import cal_hu_mac_pkg::*;
#(
  parameter int A_W       = 8,
  parameter int B_W       = 14,
  parameter int P_W       = 22,
  parameter int NUM_STAGE = 4,
  parameter int A_SIGNED  = 0,
  parameter int B_SIGNED  = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ce,
  input  tag_t           tag_in,
  input  logic [A_W-1:0] din0,
  input  logic [B_W-1:0] din1,
  output tag_t           tag_out,
  output logic [P_W-1:0] prod
);

  localparam int LAST   = NUM_STAGE - 1;
  localparam int FULL_W = A_W + B_W + 2;
  localparam int MW     = (FULL_W > P_W) ? FULL_W : P_W;

  logic [A_W-1:0] a_q, a_d;
  logic [B_W-1:0] b_q, b_d;
  tag_t           tag_q  [1:LAST];
  tag_t           tag_d  [1:LAST];
  logic [P_W-1:0] prod_q [2:LAST];
  logic [P_W-1:0] prod_d [2:LAST];

  logic signed [A_W:0]  a_x;
  logic signed [B_W:0]  b_x;
  logic signed [MW-1:0] a_m, b_m, full_m;
  logic [P_W-1:0]       mul_res;

  // Both operands become one bit wider and signed: unsigned ones get a zero
  // MSB, signed ones a copy of their sign. The product is then always signed
  // and its low P_W bits are correct for every signedness combination.
  always_comb begin
    a_x     = (A_SIGNED != 0) ? {a_q[A_W-1], a_q} : {1'b0, a_q};
    b_x     = (B_SIGNED != 0) ? {b_q[B_W-1], b_q} : {1'b0, b_q};
    a_m     = MW'(a_x);
    b_m     = MW'(b_x);
    full_m  = a_m * b_m;
    mul_res = full_m[P_W-1:0];
  end

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    tag_d  = tag_q;
    prod_d = prod_q;
    if (ce) begin
      a_d      = din0;
      b_d      = din1;
      tag_d[1] = tag_in;
      for (int s = 2; s <= LAST; s++) tag_d[s] = tag_q[s-1];
      prod_d[2] = mul_res;
      for (int s = 3; s <= LAST; s++) prod_d[s] = prod_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      tag_q  <= '{default: '0};
      prod_q <= '{default: '0};
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      tag_q  <= tag_d;
      prod_q <= prod_d;
    end
  end

  assign tag_out = tag_q[LAST];
  assign prod    = prod_q[LAST];

endmodule

// File: rtl/cal_hu_mac_pipe.sv
// ---------------------------------------------------------------------------
// cal_hu_mac_pipe
// Parametrised pipelined multiply-accumulate unit for the Hu-moment datapath.
// A sample accepted (ce=1) at edge k emerges at edge k+NUM_STAGE-1.
// Ports:
//   clk, reset (sync, active high, independent of ce), ce (clock enable)
//   in_valid, din0[A_W], din1[B_W], acc_clr, acc_en : input sample and tags
//   out_valid : dout/prod/ovf were updated by a valid sample
//   prod[P_W] : product of the emerging sample (held across bubbles)
//   dout[ACC_W]: accumulator value after this edge's update
//   ovf       : sticky overflow, cleared by a valid acc_clr sample or reset
// Build option: define CAL_HU_MAC_SAT_EN to clamp the accumulator on
// overflow instead of wrapping modulo 2^ACC_W.
// ---------------------------------------------------------------------------
module cal_hu_mac_pipe
  import cal_hu_mac_pkg::*;
#(
  parameter int A_W       = 8,
  parameter int B_W       = 14,
  parameter int P_W       = 22,
  parameter int ACC_W     = 32,
  parameter int NUM_STAGE = 4,
  parameter int A_SIGNED  = 0,
  parameter int B_SIGNED  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             in_valid,
  input  logic [A_W-1:0]   din0,
  input  logic [B_W-1:0]   din1,
  input  logic             acc_clr,
  input  logic             acc_en,
  output logic             out_valid,
  output logic [P_W-1:0]   prod,
  output logic [ACC_W-1:0] dout,
  output logic             ovf
);

  localparam bit SIGNED_MODE = (A_SIGNED != 0) || (B_SIGNED != 0);

  tag_t           tag_in, tag_s;
  logic [P_W-1:0] prod_s;

  assign tag_in = '{valid: in_valid, clr: acc_clr, en: acc_en};

  cal_hu_mac_mul_core #(
    .A_W      (A_W),
    .B_W      (B_W),
    .P_W      (P_W),
    .NUM_STAGE(NUM_STAGE),
    .A_SIGNED (A_SIGNED),
    .B_SIGNED (B_SIGNED)
  ) u_mul_core (
    .clk    (clk),
    .reset  (reset),
    .ce     (ce),
    .tag_in (tag_in),
    .din0   (din0),
    .din1   (din1),
    .tag_out(tag_s),
    .prod   (prod_s)
  );

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [P_W-1:0]   prod_q, prod_d;
  logic             out_valid_q, out_valid_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W:0]   sum;
  logic             add_ovf;
`ifdef CAL_HU_MAC_SAT_EN
  logic [ACC_W-1:0] sat_val;
`endif

  always_comb begin
    prod_ext = ACC_W'(ext_to_max(MAX_W'(prod_s), P_W, SIGNED_MODE));
    sum      = {1'b0, acc_q} + {1'b0, prod_ext};
    // Signed overflow: both addends share a sign the result does not have.
    if (SIGNED_MODE)
      add_ovf = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                (sum[ACC_W-1] != acc_q[ACC_W-1]);
    else
      add_ovf = sum[ACC_W];
`ifdef CAL_HU_MAC_SAT_EN
    // On overflow both addends have the accumulator's sign, so it picks the rail.
    sat_val = ACC_W'(sat_value(ACC_W, SIGNED_MODE, acc_q[ACC_W-1]));
`endif
  end

  always_comb begin
    acc_d       = acc_q;
    prod_d      = prod_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;
    if (ce) begin
      out_valid_d = tag_s.valid;
      if (tag_s.valid) begin
        prod_d = prod_s;
        if (tag_s.clr) begin
          acc_d = prod_ext;
          ovf_d = 1'b0;
        end else if (tag_s.en) begin
`ifdef CAL_HU_MAC_SAT_EN
          acc_d = add_ovf ? sat_val : sum[ACC_W-1:0];
`else
          acc_d = sum[ACC_W-1:0];
`endif
          ovf_d = ovf_q | add_ovf;
        end else begin
          acc_d = prod_ext;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      prod_q      <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      prod_q      <= prod_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign prod      = prod_q;
  assign dout      = acc_q;
  assign ovf       = ovf_q;

endmodule
